buzzer_request_scheduler: RTL

Shares the single board buzzer between three independent requesters (key-click, status, alarm). It latches beep requests, grants the buzzer to the highest-priority pending requester, and plays that requester's beep burst: a configurable count of fixed-length tones and gaps, timed from a 1 ms tick derived from the 50 MHz system clock. It sits between the key/alarm logic and the buzzer pin, and replaces direct per-source drive of the buzzer.

---
 rtl/buzzer_request_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/buzzer_request_scheduler.sv
// rtl/buzzer_request_scheduler.sv - priority scheduler sharing one buzzer among three beep requesters
//
// Latches beep requests from three sources, grants the buzzer to the highest
// pending source and plays that source's burst of tones and gaps, each timed
// in whole milliseconds derived from CLK.
//
// Optional feature macro: BUZZER_PREEMPT_EN
//   defined   - a higher-priority pending request aborts a burst in ON/OFF
//   undefined - bursts always run to completion
//
// Ports:
//   CLK      in   system clock (50 MHz nominal)
//   RSTn     in   asynchronous active-low reset
//   Req      in   [2:0] request levels, bit 2 highest priority
//   Grant    out  [2:0] one-hot owner of the current burst, 0 when idle
//   Busy     out  high whenever the scheduler is not idle
//   Done     out  one-cycle pulse when a burst completes normally
//   Pin_Out  out  buzzer drive, high = tone
module buzzer_request_scheduler #(
   parameter logic [15:0] T1MS   = 16'd49_999,
   parameter logic [9:0]  ON_MS  = 10'd100,
   parameter logic [9:0]  OFF_MS = 10'd50,
   parameter logic [2:0]  BEEPS0 = 3'd1,
   parameter logic [2:0]  BEEPS1 = 3'd2,
   parameter logic [2:0]  BEEPS2 = 3'd3
) (
   input  logic       CLK,
   input  logic       RSTn,
   input  logic [2:0] Req,
   output logic [2:0] Grant,
   output logic       Busy,
   output logic       Done,
   output logic       Pin_Out
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ON    = 3'd1,
      S_OFF   = 3'd2,
      S_DONE  = 3'd3,
      S_GUARD = 3'd4
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  pending;
   logic [2:0]  grant_nxt;
   logic [2:0]  left, left_nxt;
   logic [2:0]  clr_mask;
   logic [15:0] sub_cnt;
   logic [9:0]  ms_cnt;
   logic        tick;
   logic        on_end;
   logic        off_end;
   logic        preempt;

   assign tick = (sub_cnt == T1MS);

   // Phases end on the tick that would make ms reach the target, so each
   // phase lasts exactly target * (T1MS+1) cycles.
   assign on_end  = tick && (ms_cnt == ON_MS - 10'd1);
   assign off_end = tick && (ms_cnt == OFF_MS - 10'd1);

`ifdef BUZZER_PREEMPT_EN
   logic [2:0] higher;

   // Pending requests strictly above the current owner.
   always_comb begin
      higher = 3'b000;
      case (Grant)
         3'b001:  higher = pending & 3'b110;
         3'b010:  higher = pending & 3'b100;
         default: higher = 3'b000;
      endcase
   end

   assign preempt = |higher;
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      grant_nxt = Grant;
      left_nxt  = left;
      clr_mask  = 3'b000;
      case (state)
         S_IDLE: begin
            if (|pending) begin
               state_nxt = S_ON;
               if (pending[2]) begin
                  grant_nxt = 3'b100;
                  left_nxt  = BEEPS2;
               end else if (pending[1]) begin
                  grant_nxt = 3'b010;
                  left_nxt  = BEEPS1;
               end else begin
                  grant_nxt = 3'b001;
                  left_nxt  = BEEPS0;
               end
            end
         end
         S_ON: begin
            if (preempt) begin
               // Aborted owner keeps its pending bit and restarts later.
               grant_nxt = 3'b000;
               state_nxt = S_GUARD;
            end else if (on_end) begin
               state_nxt = (left > 3'd1) ? S_OFF : S_DONE;
            end
         end
         S_OFF: begin
            if (preempt) begin
               grant_nxt = 3'b000;
               state_nxt = S_GUARD;
            end else if (off_end) begin
               left_nxt  = left - 3'd1;
               state_nxt = S_ON;
            end
         end
         S_DONE: begin
            clr_mask  = Grant;
            grant_nxt = 3'b000;
            state_nxt = S_GUARD;
         end
         S_GUARD: begin
            if (off_end) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state   <= S_IDLE;
         Grant   <= 3'b000;
         left    <= 3'd0;
         pending <= 3'b000;
         sub_cnt <= 16'd0;
         ms_cnt  <= 10'd0;
      end else begin
         state   <= state_nxt;
         Grant   <= grant_nxt;
         left    <= left_nxt;
         // A new request on the same edge as the clear keeps the bit set.
         pending <= (pending & ~clr_mask) | Req;
         if (state_nxt != state) begin
            sub_cnt <= 16'd0;
            ms_cnt  <= 10'd0;
         end else if (tick) begin
            sub_cnt <= 16'd0;
            ms_cnt  <= ms_cnt + 10'd1;
         end else begin
            sub_cnt <= sub_cnt + 16'd1;
         end
      end
   end

   assign Busy    = (state != S_IDLE);
   assign Done    = (state == S_DONE);
   assign Pin_Out = (state == S_ON);

endmodule
